// File: rtl/led_pattern_ctrl_pkg.sv
// led_pattern_ctrl_pkg: mode, FSM state and colour codes shared by the LED pattern sequencer
package led_pattern_ctrl_pkg;
    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FLASH  = 2'd3;
    localparam logic [1:0] COLOR_RED   = 2'd0;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} state_e;
    function automatic logic [1:0] next_color(input logic [1:0] c);
        return (c == COLOR_GREEN) ? COLOR_RED : c + 2'd1;
    endfunction
endpackage

// File: rtl/led_pattern_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous switch inputs
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: sequencer issuing shift/load commands and colour select to the LED shift register
module led_pattern_ctrl
    import led_pattern_ctrl_pkg::*;
#(
    parameter int NB_LEDS  = 4,
    parameter int NB_MODE  = 2,
    parameter int NB_COLOR = 2
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic [NB_MODE-1:0]  i_mode,
    input  logic                i_enable,
    output logic                o_shift,
    output logic                o_dir,
    output logic                o_load,
    output logic [NB_LEDS-1:0]  o_load_data,
    output logic [NB_COLOR-1:0] o_color,
    output logic [1:0]          o_state
);
    localparam int PW = $clog2(NB_LEDS);
    localparam logic [PW-1:0] LAST = PW'(NB_LEDS - 1);
    state_e state, state_n;
    logic [NB_MODE-1:0] mode_s, mode_q, mode_n;
    logic [PW-1:0] pos, pos_n;
    logic [NB_COLOR-1:0] color_n, color_adv;
    logic [NB_LEDS-1:0] data_n;
    logic en_s, dir_q, dir_n, flash_q, flash_n, shift_n, sdir_n, load_n, seed_flash;
    sync_2ff #(.WIDTH(NB_MODE + 1)) u_sync (
        .clk(clock),
        .rst(i_reset),
        .d  ({i_enable, i_mode}),
        .q  ({en_s, mode_s})
    );
    assign color_adv  = NB_COLOR'(next_color(o_color[1:0]));
    assign seed_flash = (mode_s == NB_MODE'(MODE_FLASH));
    assign o_state    = state;
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        pos_n   = pos;
        dir_n   = dir_q;
        color_n = o_color;
        flash_n = flash_q;
        shift_n = 1'b0;
        sdir_n  = 1'b0;
        load_n  = 1'b0;
        data_n  = '0;
        case (state)
            ST_LOAD: if (i_tick && en_s) begin
                state_n = ST_RUN;
                mode_n  = mode_s;
                load_n  = 1'b1;
                data_n  = seed_flash ? '1 : NB_LEDS'(1);
                pos_n   = '0;
                dir_n   = 1'b0;
                flash_n = seed_flash;
                color_n = seed_flash ? color_adv : o_color;
            end
            ST_RUN: begin
                if (mode_s != mode_q) state_n = ST_LOAD;
                else if (!en_s) state_n = ST_HOLD;
                else if (i_tick) begin
                    case (mode_q)
                        NB_MODE'(MODE_ROT_L): begin
                            shift_n = 1'b1;
                            pos_n   = (pos == LAST) ? '0 : pos + PW'(1);
                            color_n = (pos == LAST) ? color_adv : o_color;
                        end
                        NB_MODE'(MODE_ROT_R): begin
                            shift_n = 1'b1;
                            sdir_n  = 1'b1;
                            pos_n   = (pos == '0) ? LAST : pos - PW'(1);
                            color_n = (pos == '0) ? color_adv : o_color;
                        end
                        NB_MODE'(MODE_BOUNCE): begin
                            shift_n = 1'b1;
                            if (!dir_q && pos == LAST) begin
                                dir_n  = 1'b1;
                                sdir_n = 1'b1;
                                pos_n  = LAST - PW'(1);
                            end else if (dir_q && pos == '0) begin
                                dir_n   = 1'b0;
                                pos_n   = PW'(1);
                                color_n = color_adv;
                            end else begin
                                sdir_n = dir_q;
                                pos_n  = dir_q ? pos - PW'(1) : pos + PW'(1);
                            end
                        end
                        default: begin
                            load_n  = 1'b1;
                            data_n  = flash_q ? '0 : '1;
                            flash_n = !flash_q;
                            color_n = flash_q ? o_color : color_adv;
                        end
                    endcase
                end
            end
            ST_HOLD: state_n = (mode_s != mode_q) ? ST_LOAD : (en_s ? ST_RUN : ST_HOLD);
            default: state_n = ST_LOAD;
        endcase
    end
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= ST_LOAD;
            mode_q      <= '0;
            pos         <= '0;
            dir_q       <= 1'b0;
            flash_q     <= 1'b0;
            o_color     <= NB_COLOR'(COLOR_RED);
            o_shift     <= 1'b0;
            o_dir       <= 1'b0;
            o_load      <= 1'b0;
            o_load_data <= '0;
        end else begin
            state       <= state_n;
            mode_q      <= mode_n;
            pos         <= pos_n;
            dir_q       <= dir_n;
            flash_q     <= flash_n;
            o_color     <= color_n;
            o_shift     <= shift_n;
            o_dir       <= sdir_n;
            o_load      <= load_n;
            o_load_data <= data_n;
        end
    end
endmodule
